// File: rtl/replace_order_fifo.sv
// replace_order_fifo
// Buffers fully parsed Replace Order messages from the decoder in a small
// first-word-fall-through FIFO. The order-book logic drains it over a
// valid/ready handshake. Also keeps drop and invalid-packet statistics.
// The decoder clears its field outputs one cycle after its valid pulse, so
// this FIFO is the only place the replace payload survives.

module replace_order_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       replace_internal_valid,
    input  logic                       replace_packet_invalid,
    input  logic [63:0]                replace_old_order_ref,
    input  logic [63:0]                replace_new_order_ref,
    input  logic [31:0]                replace_shares,
    input  logic [31:0]                replace_price,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_old_order_ref,
    output logic [63:0]                out_new_order_ref,
    output logic [31:0]                out_shares,
    output logic [31:0]                out_price,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count,
    output logic [CNT_W-1:0]           invalid_count,
    input  logic                       clr_stats
);

    // Pointer layout: low IDX_W bits index storage, the MSB is a wrap bit
    // that lets full and empty be told apart when the indices match.
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int DATA_W = 192;

    // Storage is not reset; only entries between the pointers are ever read.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_q,  count_d;
    logic              valid_q,  valid_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_q,   drop_d;
    logic [CNT_W-1:0]  inv_q,    inv_d;

    logic              push_req;
    logic              pop;
    logic              full;
    logic              push_acc;
    logic              drop;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] head_data;

    // Handshake decode: a push is dropped only when full with no pop this
    // cycle, because a same-cycle pop frees the slot being written.
    always_comb begin
        push_req = replace_internal_valid && !replace_packet_invalid;
        pop      = valid_q && out_ready;
        full     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        push_acc = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        wr_data  = {replace_old_order_ref, replace_new_order_ref,
                    replace_shares, replace_price};
    end

    // Next-state pointers and occupancy; the pointers wrap naturally because
    // DEPTH is a power of two, with the MSB toggling on each wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
    end

    // Statistics: clear wins over any same-cycle increment or overflow set;
    // both counters hold at all-ones instead of wrapping.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        inv_d      = inv_q;
        if (clr_stats) begin
            overflow_d = 1'b0;
            drop_d     = '0;
            inv_d      = '0;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end
            if (replace_packet_invalid && (inv_q != '1)) begin
                inv_d = inv_q + CNT_W'(1);
            end
        end
    end

    // Control and statistics registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            inv_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            inv_q      <= inv_d;
        end
    end

    // Payload write; a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst_n && push_acc) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= wr_data;
        end
    end

    // Head fields come straight from storage at the read pointer and are
    // forced to zero while empty; nothing here depends on the inputs.
    always_comb begin
        head_data = mem[rd_ptr_q[IDX_W-1:0]];
        if (!valid_q) begin
            head_data = '0;
        end
        out_old_order_ref = head_data[191:128];
        out_new_order_ref = head_data[127:64];
        out_shares        = head_data[63:32];
        out_price         = head_data[31:0];
    end

    assign out_valid     = valid_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;
    assign invalid_count = inv_q;

endmodule

// File: tb/tb_replace_order_fifo.sv
// tb_replace_order_fifo
// Directed bench for replace_order_fifo. Stimulus pushes each message it
// expects to be accepted into a scoreboard queue; a negedge monitor pops and
// compares whenever the consumer takes the head.

module tb_replace_order_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [63:0] old_ref;
        logic [63:0] new_ref;
        logic [31:0] shares;
        logic [31:0] price;
    } msg_t;

    logic              clk;
    logic              rst_n;
    logic              replace_internal_valid;
    logic              replace_packet_invalid;
    logic [63:0]       replace_old_order_ref;
    logic [63:0]       replace_new_order_ref;
    logic [31:0]       replace_shares;
    logic [31:0]       replace_price;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_old_order_ref;
    logic [63:0]       out_new_order_ref;
    logic [31:0]       out_shares;
    logic [31:0]       out_price;
    logic [$clog2(DEPTH):0] fifo_count;
    logic              overflow;
    logic [CNT_W-1:0]  drop_count;
    logic [CNT_W-1:0]  invalid_count;
    logic              clr_stats;

    int   errors = 0;
    int   checks = 0;
    msg_t scb[$];

    replace_order_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .replace_internal_valid (replace_internal_valid),
        .replace_packet_invalid (replace_packet_invalid),
        .replace_old_order_ref  (replace_old_order_ref),
        .replace_new_order_ref  (replace_new_order_ref),
        .replace_shares         (replace_shares),
        .replace_price          (replace_price),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_old_order_ref      (out_old_order_ref),
        .out_new_order_ref      (out_new_order_ref),
        .out_shares             (out_shares),
        .out_price              (out_price),
        .fifo_count             (fifo_count),
        .overflow               (overflow),
        .drop_count             (drop_count),
        .invalid_count          (invalid_count),
        .clr_stats              (clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derivable payload for a given share count.
    function automatic msg_t make_msg(input logic [31:0] shares);
        msg_t m;
        m.old_ref = {32'hA5A5_0000, shares};
        m.new_ref = {32'h5A5A_0000, ~shares};
        m.shares  = shares;
        m.price   = shares * 32'd1000 + 32'd7;
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then return to idle
    // 1 time unit later so callers sample well away from the edge.
    task automatic applyStimulus(input logic push, input logic bad, input logic ready,
                                 input logic clr, input msg_t m, input logic expect_accept);
        replace_internal_valid = push;
        replace_packet_invalid = bad;
        out_ready              = ready;
        clr_stats              = clr;
        replace_old_order_ref  = m.old_ref;
        replace_new_order_ref  = m.new_ref;
        replace_shares         = m.shares;
        replace_price          = m.price;
        if (expect_accept) scb.push_back(m);
        @(posedge clk);
        #1;
        replace_internal_valid = 1'b0;
        replace_packet_invalid = 1'b0;
        out_ready              = 1'b0;
        clr_stats              = 1'b0;
        replace_old_order_ref  = '0;
        replace_new_order_ref  = '0;
        replace_shares         = '0;
        replace_price          = '0;
    endtask

    // Monitor: compares the head against the scoreboard on every accepted
    // pop, and checks that an empty FIFO presents all-zero fields.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got shares=%0d, expected no entry", out_shares);
            end else begin
                msg_t e;
                e = scb.pop_front();
                checkOutput("pop_old_ref", out_old_order_ref, e.old_ref);
                checkOutput("pop_new_ref", out_new_order_ref, e.new_ref);
                checkOutput("pop_shares",  {32'd0, out_shares}, {32'd0, e.shares});
                checkOutput("pop_price",   {32'd0, out_price},  {32'd0, e.price});
            end
        end else if (rst_n === 1'b1 && out_valid === 1'b0) begin
            checkOutput("empty_fields_zero",
                        out_old_order_ref | out_new_order_ref | {out_shares, out_price},
                        64'd0);
        end
    end

    initial begin : stimulus
        msg_t m0;
        msg_t idle;
        idle = '0;
        rst_n = 1'b0;
        replace_internal_valid = 1'b0;
        replace_packet_invalid = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        replace_old_order_ref = '0;
        replace_new_order_ref = '0;
        replace_shares = '0;
        replace_price = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_valid",    {63'd0, out_valid}, 64'd0);
        checkOutput("rst_count",    64'(fifo_count), 64'd0);
        checkOutput("rst_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("rst_drop",     64'(drop_count), 64'd0);
        checkOutput("rst_invalid",  64'(invalid_count), 64'd0);
        rst_n = 1'b1;

        $display("[TB] single message");
        m0.old_ref = 64'h1111_2222_3333_4444;
        m0.new_ref = 64'h5555_6666_7777_8888;
        m0.shares  = 32'd100;
        m0.price   = 32'h0001_86A0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, m0, 1'b1);
        checkOutput("single_valid",  {63'd0, out_valid}, 64'd1);
        checkOutput("single_count",  64'(fifo_count), 64'd1);
        checkOutput("single_old",    out_old_order_ref, 64'h1111_2222_3333_4444);
        checkOutput("single_new",    out_new_order_ref, 64'h5555_6666_7777_8888);
        checkOutput("single_shares", {32'd0, out_shares}, 64'd100);
        checkOutput("single_price",  {32'd0, out_price}, 64'h0001_86A0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, idle, 1'b0);
        checkOutput("single_drained_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("single_drained_count", 64'(fifo_count), 64'd0);
        checkOutput("single_drained_old",   out_old_order_ref, 64'd0);

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, make_msg(32'(i)), i <= DEPTH);
        end
        checkOutput("fill_count",    64'(fifo_count), 64'd8);
        checkOutput("fill_overflow", {63'd0, overflow}, 64'd1);
        checkOutput("fill_drop",     64'(drop_count), 64'd2);
        checkOutput("fill_head",     {32'd0, out_shares}, 64'd1);

        $display("[TB] push and pop while full");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, make_msg(32'd99), 1'b1);
        checkOutput("fullpp_count", 64'(fifo_count), 64'd8);
        checkOutput("fullpp_drop",  64'(drop_count), 64'd2);
        checkOutput("fullpp_head",  {32'd0, out_shares}, 64'd2);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, idle, 1'b0);
        end
        checkOutput("fullpp_drained_count", 64'(fifo_count), 64'd0);
        checkOutput("fullpp_scb_empty", 64'(scb.size()), 64'd0);

        $display("[TB] invalid and clear");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, idle, 1'b0);
        checkOutput("clr_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("clr_drop",     64'(drop_count), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, make_msg(32'd55), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle, 1'b0);
        checkOutput("inv_count", 64'(invalid_count), 64'd3);
        checkOutput("inv_fifo_count", 64'(fifo_count), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, idle, 1'b0);
        checkOutput("inv_clr_priority", 64'(invalid_count), 64'd0);

        $display("[TB] wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, make_msg(32'd300), 1'b1);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, make_msg(32'(300 + i)), 1'b1);
        end
        checkOutput("wrap_count", 64'(fifo_count), 64'd1);
        checkOutput("wrap_head",  {32'd0, out_shares}, 64'd320);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, idle, 1'b0);
        checkOutput("wrap_drained", 64'(fifo_count), 64'd0);

        $display("[TB] mid-operation reset");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, make_msg(32'(400 + i)), 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle, 1'b0);
        checkOutput("prerst_count",   64'(fifo_count), 64'd5);
        checkOutput("prerst_invalid", 64'(invalid_count), 64'd1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, make_msg(32'd500), 1'b0);
        scb.delete();
        rst_n = 1'b1;
        checkOutput("midrst_count",    64'(fifo_count), 64'd0);
        checkOutput("midrst_valid",    {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("midrst_drop",     64'(drop_count), 64'd0);
        checkOutput("midrst_invalid",  64'(invalid_count), 64'd0);

        $display("[TB] operation after reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, make_msg(32'd600), 1'b1);
        checkOutput("postrst_head", {32'd0, out_shares}, 64'd600);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, idle, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, idle, 1'b0);
        checkOutput("postrst_count", 64'(fifo_count), 64'd0);
        checkOutput("final_scb_empty", 64'(scb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
